// File: rtl/dmem_pkg.sv
// Shared types, response-entry layout and width helpers for the data memory controller.
package dmem_pkg;

  typedef enum logic {
    DMEM_OP_READ  = 1'b0,
    DMEM_OP_WRITE = 1'b1
  } dmem_op_e;

  localparam int DMEM_DATA_W = 32;
  localparam int BE_W        = DMEM_DATA_W / 8;
  localparam int RSP_W       = DMEM_DATA_W + 2;

  // Response entry layout: {rdata, we, err}
  localparam int RSP_ERR_OFF   = 0;
  localparam int RSP_WE_OFF    = 1;
  localparam int RSP_RDATA_OFF = 2;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int rsp_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Two-entry response FIFO with occupancy output; entries clear on reset so the
// head reads as zero while empty after reset.
module dmem_rsp_fifo #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] ent_q [2];
  logic [W-1:0] ent_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    ent_d    = ent_q;
    do_push  = push && (cnt_q != 2'd2);
    do_pop   = pop && (cnt_q != 2'd0);
    if (do_push) ent_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout  = ent_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with byte-lane writes and a 2-deep buffered response channel.
// Optional out-of-range detection is enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_we,
  output logic                  rsp_err
);

  localparam int LANES = be_w(DATA_W);
  localparam int ENT_W = rsp_w(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic              accept;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;
  logic [ENT_W-1:0]  push_ent;
  logic [ENT_W-1:0]  head_ent;
  logic [1:0]        occ;
  logic              unused_err_bit;

  assign mem_idx = req_addr[IDX_W-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  assign in_range       = ({1'b0, req_addr} < DEPTH_L);
  assign rsp_err        = head_ent[RSP_ERR_OFF];
  assign unused_err_bit = 1'b0;
`else
  assign in_range       = 1'b1;
  assign rsp_err        = 1'b0;
  assign unused_err_bit = head_ent[RSP_ERR_OFF];
  if (DEPTH != (1 << ADDR_W)) begin : g_depth_chk
    $error("data_mem_ctrl: DEPTH must equal 2**ADDR_W without bounds checking");
  end
`endif

  // Ready depends only on registered occupancy, never on rsp_ready.
  assign req_ready = (occ < 2'd2);
  assign rsp_valid = (occ != 2'd0);

  always_comb begin
    accept  = req_valid && req_ready;
    wr_en   = accept && (dmem_op_e'(req_we) == DMEM_OP_WRITE) && in_range;
    rd_data = '0;
    if ((dmem_op_e'(req_we) == DMEM_OP_READ) && in_range) rd_data = mem_q[mem_idx];
    push_ent                          = '0;
    push_ent[RSP_RDATA_OFF +: DATA_W] = rd_data;
    push_ent[RSP_WE_OFF]              = req_we;
    push_ent[RSP_ERR_OFF]             = !in_range;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_be[i]) mem_q[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  dmem_rsp_fifo #(.W(ENT_W)) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (push_ent),
    .pop   (rsp_valid && rsp_ready),
    .dout  (head_ent),
    .count (occ)
  );

  assign rsp_rdata = head_ent[RSP_RDATA_OFF +: DATA_W];
  assign rsp_we    = head_ent[RSP_WE_OFF];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a driver pushes expected responses from a
// behavioural memory model, and an independent monitor pops and compares them.
module tb_data_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam int DEPTH  = 1000;
`else
  localparam int DEPTH  = 1024;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_be;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_we;
  logic              rsp_err;

  data_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_we    (rsp_we),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        we;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] ref_mem [int];
  int          checks   = 0;
  int          failures = 0;
  int          accepts  = 0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: what the memory should hold and what each accepted request returns.
  task automatic model_accept(input logic we, input int addr, input logic [3:0] be,
                              input logic [31:0] wd);
    rsp_t        r;
    logic [31:0] w;
    r.we    = we;
    r.err   = (addr >= DEPTH);
    r.rdata = 32'd0;
    if (!r.err) begin
      if (we) begin
        w = ref_mem.exists(addr) ? ref_mem[addr] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[addr] = w;
      end else begin
        r.rdata = ref_mem[addr];
      end
    end
    exp_q.push_back(r);
    accepts++;
  endtask

  // Present a request at a falling edge and hold it until accepted; returns at posedge+1.
  task automatic do_req(input logic we, input int addr, input logic [3:0] be,
                        input logic [31:0] wd, output int stalls);
    bit rdy;
    bit done;
    stalls = 0;
    done   = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = ADDR_W'(addr);
    req_be    = be;
    req_wdata = wd;
    while (!done) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin
        model_accept(we, addr, be, wd);
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 100) begin
          checks++;
          failures++;
          $display("FAIL req_accept_timeout actual=stalled required=accepted addr=%0d", addr);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic set_rdy(input logic v);
    @(negedge clk);
    #1 rsp_ready = v;
  endtask

  task automatic drain();
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      #3;
      if (!rsp_valid) break;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=rsp_valid_stuck required=empty");
    end
  endtask

  // Monitor: compare every response the consumer takes against the scoreboard head.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=%0h required=none", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("rsp_entry", {rsp_rdata, rsp_we, rsp_err}, {e.rdata, e.we, e.err});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int          st;
    int          total;
    int          base;
    int          a;
    logic [31:0] d;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_fields", {rsp_rdata, rsp_we, rsp_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full write then read, 1-cycle latency
    do_req(1'b1, 5, 4'hF, 32'hDEADBEEF, st);
    check("t1_wr_valid", rsp_valid, 1);
    check("t1_wr_rsp", {rsp_rdata, rsp_we}, {32'd0, 1'b1});
    do_req(1'b0, 5, 4'hF, 32'h0, st);
    check("t1_rd_valid", rsp_valid, 1);
    check("t1_rd_rsp", {rsp_rdata, rsp_we}, {32'hDEADBEEF, 1'b0});

    // Partial lane write
    do_req(1'b1, 7, 4'hF, 32'h11223344, st);
    do_req(1'b1, 7, 4'b0101, 32'hAABBCCDD, st);
    do_req(1'b1, 8, 4'b0000, 32'hFFFFFFFF, st);
    do_req(1'b0, 7, 4'h0, 32'h0, st);
    check("t2_partial", rsp_rdata, 32'h11BB33DD);

    // Prewrite a small working set
    for (int i = 0; i < 16; i++) do_req(1'b1, i, 4'hF, $urandom, st);
    do_req(1'b1, 8, 4'b0000, 32'hFFFFFFFF, st);
    do_req(1'b0, 8, 4'h0, 32'h0, st);
    check("t2_be_zero", rsp_rdata, ref_mem[8]);

    // Backpressure: only two accepts while rsp_ready is low
    drain();
    set_rdy(1'b0);
    base = accepts;
    fork
      begin
        for (int i = 0; i < 4; i++) do_req(1'b0, i, 4'h0, 32'h0, st);
      end
      begin
        repeat (4) @(negedge clk);
        #3;
        check("bp_req_ready", req_ready, 0);
        check("bp_accepts", accepts - base, 2);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_head_stable", rsp_rdata, ref_mem[0]);
        set_rdy(1'b1);
      end
    join
    check("bp_total_accepts", accepts - base, 4);

    // Back-to-back alternating write/read stream
    drain();
    total = 0;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 15);
      d = $urandom;
      do_req(1'b1, a, 4'hF, d, st);
      total += st;
      do_req(1'b0, a, 4'h0, 32'h0, st);
      total += st;
      check("stream_rd", rsp_rdata, d);
    end
    check("stream_stalls", total, 0);

    // Asynchronous reset with two responses buffered
    drain();
    set_rdy(1'b0);
    do_req(1'b0, 0, 4'h0, 32'h0, st);
    do_req(1'b0, 1, 4'h0, 32'h0, st);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_post_ready", req_ready, 1);
    set_rdy(1'b1);
    do_req(1'b0, 2, 4'h0, 32'h0, st);
    check("arst_mem_kept", rsp_rdata, ref_mem[2]);

`ifdef DMEM_BOUNDS_CHECK_EN
    drain();
    do_req(1'b1, 999, 4'hF, 32'hCAFEF00D, st);
    do_req(1'b1, 1000, 4'hF, 32'h12345678, st);
    check("oob_wr", {rsp_err, rsp_we, rsp_rdata}, {1'b1, 1'b1, 32'd0});
    do_req(1'b0, 1000, 4'h0, 32'h0, st);
    check("oob_rd", {rsp_err, rsp_we, rsp_rdata}, {1'b1, 1'b0, 32'd0});
    do_req(1'b0, 999, 4'h0, 32'h0, st);
    check("oob_neighbour", {rsp_err, rsp_rdata}, {1'b0, 32'hCAFEF00D});
`endif

    // Randomized traffic with random consumer backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      do_req(1'($urandom_range(0, 1)), $urandom_range(0, 15),
             4'($urandom_range(0, 15)), $urandom, st);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    rand_rdy = 1'b0;
    set_rdy(1'b1);
    drain();
    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
